branch_target_predictor: RTL and testbench
==========================================

# branch_target_predictor

Direct-mapped branch target buffer with per-entry 2-bit saturating counters. It supplies the fetch stage with hit, predicted direction and predicted target, and it is trained by branches resolving in EX. It is the prediction resource whose `hit_E` / `prediction_E` values, piped to EX, drive the hazard unit's flush and target-select decisions. It owns all allocation, replacement, counter training and invalidation of that resource.

## Interface
- `ENTRIES`, 16: number of BTB entries; power of two, ≥2. `IDX_W = log2(ENTRIES)`.
- `PC_WIDTH`, 32: instruction-word PC width (PC increments by 1). `TAG_W = PC_WIDTH - IDX_W`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pc_F` in PC_WIDTH: fetch-stage PC to look up.
- `hit_F` out 1: valid entry with matching tag for `pc_F`.
- `prediction_F` out 1: predicted taken (`hit_F & ctr[1]`).
- `target_F` out PC_WIDTH: stored target on hit; 0 on miss.
- `branch_E`, `bne_E` in 1 each: a conditional branch is in EX.
- `stall_EX` in 1: EX is held this cycle; training is suppressed.
- `pc_E` in PC_WIDTH: PC of the EX branch.
- `real_Value_E` in 1: resolved outcome (1 = taken).
- `target_E` in PC_WIDTH: resolved taken target.
- `btb_clear` in 1: synchronous invalidate-all request.

## Operation
- Index is `pc[IDX_W-1:0]`; tag is `pc[PC_WIDTH-1:IDX_W]`. Each entry holds `valid`, `tag`, `target` and `ctr[1:0]`.
- Lookup is purely combinational from entry state; it involves no internal state machine.
- `train = (branch_E | bne_E) & ~stall_EX`. Training occurs exactly once per branch, on the cycle the branch leaves EX. It is not repeated across stall cycles.
- On `train`, for the EX entry `e = idx(pc_E)`:
  - Tag hit, taken: `ctr` saturating increment (max 11); `target <= target_E`.
  - Tag hit, not taken: `ctr` saturating decrement (min 00); `target` unchanged.
  - Miss (invalid or tag mismatch), taken: allocate. Set `valid=1`, `tag=tag(pc_E)`, `target=target_E`, `ctr=10`. This replaces any prior occupant.
  - Miss, not taken: no state change.
- `btb_clear` on a rising edge sets every `valid` to 0 and every `ctr` to 01. It has priority over a coincident `train`, and that branch's training is dropped.
- Counter encoding:
  - 00 strong not-taken.
  - 01 weak not-taken.
  - 10 weak taken.
  - 11 strong taken.
- Only `ctr[1]` is visible as direction.

## Timing
- Reset (`rst`=0, asynchronous): all `valid`=0, all `ctr`=01, performance counters 0. Consequently `hit_F`=0, `prediction_F`=0 and `target_F`=0 immediately, without waiting for a clock.
- Reset deassertion is sampled at `clk`. The first training can occur on the first rising edge after deassertion.
- Lookup latency is 0: outputs follow `pc_F` in the same cycle.
- Training latency is 1: state is written at the rising edge that ends the `train` cycle, and is visible to lookup from the next cycle.
- If `pc_F` and `pc_E` map to the same index in the same cycle, lookup returns the pre-update entry. There is no write-to-read bypass.
- Reset asserted mid-operation discards any in-flight training at once. Tables return to reset values.
- Tags compare the full `TAG_W` bits. PC wrap-around from `2^PC_WIDTH-1` to 0 needs no special handling.

## Configuration
- Macro `BTB_PERF_CNT_EN`.
- When defined, the block adds two output ports, each 32 bits, reset to 0 and incremented at most once per cycle:
  - `perf_branches`: increments on every `train`.
  - `perf_mispredicts`: increments on `train` when the EX-time prediction was wrong. A wrong prediction is `(hit & ctr[1]) != real_Value_E`, evaluated on pre-update state for `pc_E`.
- Both counters wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and registers are absent, and behaviour is otherwise identical.

## Test plan
- Post-reset lookup: reset, `pc_F`=0x40 → `hit_F`=0, `prediction_F`=0, `target_F`=0. Train not-taken at `pc_E`=0x40 → still miss next cycle.
- Allocation and training:
  - Train taken at `pc_E`=0x13, `target_E`=0x80 → next cycle `pc_F`=0x13 gives hit=1, prediction=1, target=0x80.
  - Two further taken trainings leave `ctr`=11.
  - Three not-taken trainings → prediction=0, hit=1.
- Conflict replacement (ENTRIES=16): allocate 0x13 taken, then train taken at 0x23 with target 0x90 → 0x13 misses, 0x23 hits with target 0x90.
- Stall gating: branch held in EX for 3 cycles with `stall_EX`=1,1,0 and taken → counter advances exactly one step (e.g. 10→11, not saturation by repeats).
- Clear priority: assert `btb_clear` and `train` in the same cycle → all lookups miss next cycle. With `BTB_PERF_CNT_EN`, `perf_branches` still increments by 1.
- Async reset mid-run: populate 4 entries, pulse `rst` low between clock edges → `hit_F` drops to 0 before the next edge. With the macro defined, both performance counters read 0.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit saturating counters.
// The fetch stage gets a zero-latency lookup (hit, direction, target) for pc_F.
// The table is trained by conditional branches leaving EX.
// Optional feature macro: BTB_PERF_CNT_EN adds branch and mispredict counters.
module branch_target_predictor #(
    parameter int ENTRIES  = 16,
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    // Fetch-side lookup
    input  logic [PC_WIDTH-1:0] pc_F,
    output logic                hit_F,
    output logic                prediction_F,
    output logic [PC_WIDTH-1:0] target_F,
    // EX-side training
    input  logic                branch_E,
    input  logic                bne_E,
    input  logic                stall_EX,
    input  logic [PC_WIDTH-1:0] pc_E,
    input  logic                real_Value_E,
    input  logic [PC_WIDTH-1:0] target_E,
    input  logic                btb_clear
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_branches,
    output logic [31:0]         perf_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX_W;

    // Two-bit direction counter; only bit 1 is exposed as the prediction.
    typedef enum logic [1:0] {
        CTR_STRONG_NT = 2'b00,
        CTR_WEAK_NT   = 2'b01,
        CTR_WEAK_T    = 2'b10,
        CTR_STRONG_T  = 2'b11
    } ctr_t;

    // Entry storage. valid and ctr carry reset state; tag and target do not.
    logic                valid_q  [ENTRIES];
    ctr_t                ctr_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];

    // Fetch-side index/tag split
    logic [IDX_W-1:0]    f_idx;
    logic [TAG_W-1:0]    f_tag;

    // EX-side index/tag split and pre-update entry view
    logic [IDX_W-1:0]    e_idx;
    logic [TAG_W-1:0]    e_tag;
    logic                e_hit;
    ctr_t                e_ctr;
    ctr_t                ctr_next;
    logic                train;
    logic                alloc;

    assign f_idx = pc_F[IDX_W-1:0];
    assign f_tag = pc_F[PC_WIDTH-1:IDX_W];
    assign e_idx = pc_E[IDX_W-1:0];
    assign e_tag = pc_E[PC_WIDTH-1:IDX_W];

    // A branch trains only on the cycle it actually leaves EX.
    assign train = (branch_E | bne_E) & ~stall_EX;

    // Fetch lookup: purely combinational from the stored entries, no bypass of
    // a same-cycle training write.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path can leave it unassigned and infer a latch.
        hit_F        = 1'b0;
        prediction_F = 1'b0;
        target_F     = '0;
        if (valid_q[f_idx] && (tag_q[f_idx] == f_tag)) begin
            hit_F        = 1'b1;
            prediction_F = ctr_q[f_idx][1];
            target_F     = target_q[f_idx];
        end
    end

    // EX-side view of the entry being trained, using pre-update state.
    always_comb begin
        e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        e_ctr = ctr_q[e_idx];
        alloc = train && !e_hit && real_Value_E;
    end

    // Saturating counter step in the direction of the resolved outcome.
    always_comb begin
        ctr_next = e_ctr;
        if (real_Value_E) begin
            if (e_ctr != CTR_STRONG_T) begin
                ctr_next = ctr_t'(e_ctr + 2'd1);
            end
        end else begin
            if (e_ctr != CTR_STRONG_NT) begin
                ctr_next = ctr_t'(e_ctr - 2'd1);
            end
        end
    end

    // Valid bits and counters: reset/clear to invalid + weak not-taken; clear
    // wins over a coincident training; a hit steps the counter, a taken miss
    // allocates at weak taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                // NOTE: state registers use non-blocking assignment so every
                // flop samples pre-edge values regardless of statement order.
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
        end else if (btb_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
        end else if (train) begin
            if (e_hit) begin
                ctr_q[e_idx] <= ctr_next;
            end else if (alloc) begin
                valid_q[e_idx] <= 1'b1;
                ctr_q[e_idx]   <= CTR_WEAK_T;
            end
        end
    end

    // Tag and target payload: written on every taken training (allocation or
    // taken hit). On a hit the tag write is a no-op since the tag matches.
    // NOTE: the payload arrays have no reset; an entry is never observed
    // while its valid bit is clear, so resetting them would only cost flops.
    always_ff @(posedge clk) begin
        if (rst && !btb_clear && train && real_Value_E) begin
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= target_E;
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic mispredict;

    // Prediction made for pc_E from pre-update state disagreed with the outcome.
    assign mispredict = (e_hit & e_ctr[1]) != real_Value_E;

    // Performance counters: count every training and every wrong prediction;
    // they count even when a clear drops the table update. Both wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (train) begin
            perf_branches <= perf_branches + 32'd1;
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor (ENTRIES=16, PC_WIDTH=32).
// A table model compared every cycle on the falling edge, plus literal
// expectations for the directed scenarios. Honours BTB_PERF_CNT_EN if defined.
module tb_branch_target_predictor;

    localparam int ENTRIES  = 16;
    localparam int PC_WIDTH = 32;

    logic                clk;
    logic                rst;
    logic [PC_WIDTH-1:0] pc_F;
    logic                hit_F;
    logic                prediction_F;
    logic [PC_WIDTH-1:0] target_F;
    logic                branch_E;
    logic                bne_E;
    logic                stall_EX;
    logic [PC_WIDTH-1:0] pc_E;
    logic                real_Value_E;
    logic [PC_WIDTH-1:0] target_E;
    logic                btb_clear;
`ifdef BTB_PERF_CNT_EN
    logic [31:0]         perf_branches;
    logic [31:0]         perf_mispredicts;
`endif

    branch_target_predictor #(.ENTRIES(ENTRIES), .PC_WIDTH(PC_WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_F         (pc_F),
        .hit_F        (hit_F),
        .prediction_F (prediction_F),
        .target_F     (target_F),
        .branch_E     (branch_E),
        .bne_E        (bne_E),
        .stall_EX     (stall_EX),
        .pc_E         (pc_E),
        .real_Value_E (real_Value_E),
        .target_E     (target_E),
        .btb_clear    (btb_clear)
`ifdef BTB_PERF_CNT_EN
        ,
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    logic [31:0] m_branches;
    logic [31:0] m_mispred;

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_branches = 0;
        m_mispred  = 0;
    endtask

    task automatic model_lookup(input logic [31:0] pc, output bit hit, output bit pred,
                                output logic [31:0] tgt);
        int i;
        i    = int'(pc % ENTRIES);
        hit  = m_valid[i] && (m_tag[i] == pc / ENTRIES);
        pred = hit && (m_ctr[i] >= 2);
        tgt  = hit ? m_target[i] : 32'd0;
    endtask

    // Applied at each rising edge using the inputs held during that cycle.
    task automatic model_update();
        bit          trn, hit, pred;
        logic [31:0] tgt;
        int          i;
        trn = (branch_E || bne_E) && !stall_EX;
        model_lookup(pc_E, hit, pred, tgt);
        if (trn) begin
            m_branches = m_branches + 1;
            if (pred != real_Value_E) m_mispred = m_mispred + 1;
        end
        i = int'(pc_E % ENTRIES);
        if (btb_clear) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
        end else if (trn) begin
            if (hit) begin
                if (real_Value_E) begin
                    m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = target_E;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (real_Value_E) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = pc_E / ENTRIES;
                m_target[i] = target_E;
                m_ctr[i]    = 2;
            end
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        bit          eh, ep;
        logic [31:0] et;
        if (cmp_en && rst === 1'b1) begin
            model_lookup(pc_F, eh, ep, et);
            check("model_hit_F", hit_F, eh);
            check("model_prediction_F", prediction_F, ep);
            check("model_target_F", target_F, et);
`ifdef BTB_PERF_CNT_EN
            check("model_perf_branches", perf_branches, m_branches);
            check("model_perf_mispredicts", perf_mispredicts, m_mispred);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        branch_E     = 1'b0;
        bne_E        = 1'b0;
        stall_EX     = 1'b0;
        real_Value_E = 1'b0;
        btb_clear    = 1'b0;
    endtask

    task automatic drive(input logic br, input logic bn, input logic st, input logic [31:0] pce,
                         input logic tk, input logic [31:0] tgt, input logic clr);
        @(negedge clk);
        #1;
        branch_E     = br;
        bne_E        = bn;
        stall_EX     = st;
        pc_E         = pce;
        real_Value_E = tk;
        target_E     = tgt;
        btb_clear    = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        idle_inputs();
    endtask

    task automatic train(input logic [31:0] pce, input logic tk, input logic [31:0] tgt);
        drive(1'b1, 1'b0, 1'b0, pce, tk, tgt, 1'b0);
        tick();
    endtask

    task automatic look(input string name, input logic [31:0] pc, input logic eh,
                        input logic ep, input logic [31:0] et);
        @(negedge clk);
        #1;
        pc_F = pc;
        #1;
        check({name, "_hit"}, hit_F, eh);
        check({name, "_pred"}, prediction_F, ep);
        check({name, "_tgt"}, target_F, et);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] branches_before;
        int          miss_cnt;
        idle_inputs();
        pc_E     = '0;
        target_E = '0;
        pc_F     = 32'h40;
        rst      = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        #1;
        check("reset_hit", hit_F, 1'b0);
        check("reset_pred", prediction_F, 1'b0);
        check("reset_tgt", target_F, 32'h0);
`ifdef BTB_PERF_CNT_EN
        check("reset_perf_br", perf_branches, 32'h0);
        check("reset_perf_mp", perf_mispredicts, 32'h0);
`endif
        @(negedge clk);
        rst    = 1'b1;
        cmp_en = 1'b1;

        // Not-taken training at an empty slot allocates nothing.
        train(32'h40, 1'b0, 32'h77);
        look("nt_no_alloc", 32'h40, 1'b0, 1'b0, 32'h0);

        // Allocation: ctr 10, then two taken steps to 11.
        train(32'h13, 1'b1, 32'h80);
        look("alloc_13", 32'h13, 1'b1, 1'b1, 32'h80);
        train(32'h13, 1'b1, 32'h80);
        train(32'h13, 1'b1, 32'h80);
        // 11 -> 10 still taken; two more reach 00.
        train(32'h13, 1'b0, 32'h0);
        look("ctr_sat_13", 32'h13, 1'b1, 1'b1, 32'h80);
        train(32'h13, 1'b0, 32'h0);
        train(32'h13, 1'b0, 32'h0);
        look("nt3_13", 32'h13, 1'b1, 1'b0, 32'h80);

        // Conflict replacement on index 3.
        train(32'h13, 1'b1, 32'h80);
        train(32'h23, 1'b1, 32'h90);
        look("evicted_13", 32'h13, 1'b0, 1'b0, 32'h0);
        look("repl_23", 32'h23, 1'b1, 1'b1, 32'h90);

        // Stall gating: drive 0x23 down to 00, then one taken branch held
        // through two stall cycles must advance it by exactly one step.
        train(32'h23, 1'b0, 32'h0);
        train(32'h23, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 1'b1, 32'h23, 1'b1, 32'h90, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b1, 32'h23, 1'b1, 32'h90, 1'b0); tick();
        drive(1'b1, 1'b0, 1'b0, 32'h23, 1'b1, 32'h90, 1'b0); tick();
        look("stall_23", 32'h23, 1'b1, 1'b0, 32'h90);

        // Same-index lookup during training sees the pre-update entry.
        drive(1'b1, 1'b0, 1'b0, 32'h23, 1'b1, 32'hA0, 1'b0);
        pc_F = 32'h23;
        #1;
        check("nobypass_tgt", target_F, 32'h90);
        check("nobypass_pred", prediction_F, 1'b0);
        tick();
        look("after_upd_23", 32'h23, 1'b1, 1'b1, 32'hA0);

        // bne path at the top of the PC space; full tag compare.
        drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h5, 1'b0);
        tick();
        look("top_pc", 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h5);
        look("top_alias", 32'h0000_000F, 1'b0, 1'b0, 32'h0);

        // Clear has priority over a coincident training.
        branches_before = m_branches;
        drive(1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 32'h11, 1'b1);
        tick();
`ifdef BTB_PERF_CNT_EN
        check("clear_perf_br", perf_branches, branches_before + 32'd1);
`endif
        look("clear_13", 32'h13, 1'b0, 1'b0, 32'h0);
        look("clear_23", 32'h23, 1'b0, 1'b0, 32'h0);
        look("clear_55", 32'h55, 1'b0, 1'b0, 32'h0);
        miss_cnt = 0;
        for (int i = 0; i < ENTRIES; i++) begin
            @(negedge clk);
            #1;
            pc_F = 32'(i);
            #1;
            if (hit_F == 1'b0) miss_cnt++;
        end
        check("clear_all_miss", 32'(miss_cnt), 32'(ENTRIES));

        // Populate four entries, then asynchronous reset between edges.
        for (int i = 1; i <= 4; i++) begin
            train(32'h100 + 32'(i), 1'b1, 32'h200 + 32'(i));
        end
        look("pop_101", 32'h101, 1'b1, 1'b1, 32'h201);
        @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_hit", hit_F, 1'b0);
        check("async_rst_tgt", target_F, 32'h0);
`ifdef BTB_PERF_CNT_EN
        check("async_rst_perf_br", perf_branches, 32'h0);
        check("async_rst_perf_mp", perf_mispredicts, 32'h0);
`endif
        #1;
        rst = 1'b1;
        look("post_rst_102", 32'h102, 1'b0, 1'b0, 32'h0);
        train(32'h104, 1'b1, 32'h321);
        look("post_rst_alloc", 32'h104, 1'b1, 1'b1, 32'h321);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
